// File: rtl/fifo_unload_ser_n_m_pkg.sv
// Shared types and default widths for the FIFO unload serialiser.
package fifo_unload_pkg;

   localparam int N_DEF     = 32;
   localparam int M_DEF     = 16;
   localparam int ADDR_DEF  = 4;
   localparam int FRM_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      SEND,
      DONE
   } state_t;

endpackage

// File: rtl/fifo_unload_ser_n_m_if.sv
// FIFO-side and stream-side signals of the unload serialiser, bundled.
interface fifo_unload_ser_n_m_if
   import fifo_unload_pkg::*;
#(
   parameter int n     = N_DEF,
   parameter int m     = M_DEF,
   parameter int frm_w = FRM_W_DEF
);

   logic             clr_i;
   logic             full_i;
   logic [n-1:0]     data_i [m];
   logic             ena_rd_o;
   logic [n-1:0]     data_o;
   logic             valid_o;
   logic             ready_i;
   logic             last_o;
   logic             busy_o;
   logic [frm_w-1:0] frm_o;
   logic             ovf_o;

   modport slave (
      input  clr_i, full_i, data_i, ready_i,
      output ena_rd_o, data_o, valid_o, last_o, busy_o, frm_o, ovf_o
   );

   modport master (
      output clr_i, full_i, data_i, ready_i,
      input  ena_rd_o, data_o, valid_o, last_o, busy_o, frm_o, ovf_o
   );

endinterface

// File: rtl/fifo_unload_ser_n_m_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level signal.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so both flops sample
   // the pre-edge values and the chain really is two stages deep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/fifo_unload_ser_n_m.sv
// Snapshots a full m-word FIFO buffer and streams it out oldest-first over
// valid/ready, counting completed frames and flagging missed ones.
module fifo_unload_ser_n_m
   import fifo_unload_pkg::*;
#(
   parameter int n       = N_DEF,
   parameter int m       = M_DEF,
   parameter int address = ADDR_DEF,
   parameter int frm_w   = FRM_W_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   fifo_unload_ser_n_m_if.slave  bus
);

   state_t             state, state_nx;
   logic               full_s, full_q;
   logic [address-1:0] idx;
   logic [n-1:0]       shadow [m];
   logic [n-1:0]       data_hold;
   logic [frm_w-1:0]   frm_q;
   logic               ovf_q;
   logic               xfer, last_w, ovf_edge;

   sync_2ff u_sync_full (
      .clk   (clk_i),
      .rst_n (rst_i),
      .d     (bus.full_i),
      .q     (full_s)
   );

   assign last_w   = (idx == address'(m - 1));
   assign xfer     = (state == SEND) && bus.ready_i;
   // A fresh full flag while still busy means the FIFO refilled under us.
   assign ovf_edge = full_s && !full_q && (state != IDLE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: next state defaults to the current state before the case, so no
   // path leaves state_nx unassigned and no latch is inferred.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (full_s)          state_nx = CAPTURE;
         CAPTURE:                      state_nx = SEND;
         SEND:    if (xfer && last_w)  state_nx = DONE;
         DONE:    if (!full_s)         state_nx = IDLE;
         default:                      state_nx = IDLE;
      endcase
   end

   // NOTE: the shadow array is reset along with everything else so the
   // stream never exposes stale words after an asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < m; k++) shadow[k] <= '0;
         idx       <= '0;
         data_hold <= '0;
      end else begin
         if (state == IDLE && full_s) begin
            for (int k = 0; k < m; k++) shadow[k] <= bus.data_i[k];
            idx <= '0;
         end
         if (state == SEND) data_hold <= shadow[idx];
         if (xfer)          idx       <= idx + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         full_q <= 1'b0;
         frm_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         full_q <= full_s;
         if (bus.clr_i) begin
            frm_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            if (xfer && last_w) frm_q <= frm_q + 1'b1;
            if (ovf_edge)       ovf_q <= 1'b1;
         end
      end
   end

   // Outside SEND the word output parks on the last value it showed.
   assign bus.data_o   = (state == SEND) ? shadow[idx] : data_hold;
   assign bus.valid_o  = (state == SEND);
   assign bus.last_o   = (state == SEND) && last_w;
   assign bus.ena_rd_o = (state == CAPTURE);
   assign bus.busy_o   = (state != IDLE);
   assign bus.frm_o    = frm_q;
   assign bus.ovf_o    = ovf_q;

endmodule

// File: doc/fifo_unload_ser_n_m.md
Name: fifo_unload_ser_n_m

Overview:
- Downstream consumer of the asynchronous m-word FIFO buffer.
- Waits for the FIFO full flag, snapshots the whole m-word parallel buffer into shadow registers and pulses a read enable back to the FIFO.
- Streams the captured words out one per accepted handshake on a valid/ready interface, oldest word (index 0) first.
- Runs on the system clock clk_i; the full flag arrives from the FIFO's mixed-clock domain and is synchronised internally.

Parameters:
- n, 32, data word width
- m, 16, number of words in the FIFO buffer (frame length)
- address, 4, index width; must satisfy 2**address >= m
- frm_w, 8, width of the completed-frame counter

Ports:
- clk_i  in  1  system clock; all state changes on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- clr_i  in  1  synchronous clear of ovf_o and frm_o
- full_i  in  1  FIFO full flag; asynchronous to clk_i
- data_i  in  n x [0:m-1]  FIFO parallel buffer; index 0 is the oldest word
- ena_rd_o  out  1  read-enable pulse to the FIFO
- data_o  out  n  current output word
- valid_o  out  1  data_o is valid
- ready_i  in  1  downstream accepts data_o
- last_o  out  1  data_o is word m-1 of the frame
- busy_o  out  1  FSM is not in IDLE
- frm_o  out  frm_w  count of completed frames; wraps
- ovf_o  out  1  sticky flag: a frame was missed

Behaviour:
- Reset (rst_i=0, asynchronous, takes effect immediately, including mid-frame): every output is 0 (ena_rd_o, data_o, valid_o, last_o, busy_o, frm_o, ovf_o). State=IDLE, idx=0, shadow registers=0, synchroniser flops=0.
- Synchroniser: 2-flop chain on full_i gives full_s. full_i sampled high at edge E gives full_s=1 after edge E+1.
- FSM states: IDLE, CAPTURE, SEND, DONE.
- IDLE:
  - full_s=1 -> CAPTURE on the next edge.
  - On that same edge, shadow[k] <= data_i[k] for all k, and idx <= 0.
- CAPTURE (exactly 1 cycle):
  - ena_rd_o=1; ena_rd_o is 1 only in this state.
  - -> SEND unconditionally.
- SEND:
  - valid_o=1, data_o=shadow[idx], last_o=(idx==m-1).
  - Transfer occurs when valid_o & ready_i at an edge; then idx <= idx+1.
  - Transfer with idx==m-1: -> DONE, frm_o <= frm_o+1 (modulo 2**frm_w).
  - No transfer: data_o, last_o and idx hold; no duplicated or skipped words.
- DONE:
  - valid_o=0.
  - full_s=0 -> IDLE. A still-asserted full flag never re-triggers.
- Latency from full_i sampled high at edge E:
  - ena_rd_o high during the cycle after edge E+2.
  - valid_o rises after edge E+3.
  - With ready_i=1 throughout, a frame is m consecutive cycles.
- busy_o=1 in CAPTURE, SEND and DONE.
- Snapshot isolation: changes on data_i after capture do not affect the words being sent.
- ovf_o:
  - Set when full_s shows a 0->1 edge while state is not IDLE.
  - Sticky; cleared only by rst_i or clr_i.
  - The current frame still completes unchanged.
- clr_i=1 for one edge: frm_o<=0, ovf_o<=0. If an overflow edge and clr_i coincide, clr_i wins.
- data_o outside SEND: holds the last driven value. Its value is only meaningful while valid_o=1.

Decomposition:
- Package fifo_unload_pkg:
  - state typedef enum {IDLE, CAPTURE, SEND, DONE}
  - default width constants
- Sub-module sync_2ff: 2-flop synchroniser, 1 bit, async active-low reset to 0. Instantiate once for full_i.
- Everything else stays in the top module: FSM, shadow register array, idx counter, output mux, frame counter, ovf logic.

Test Plan:
1. Reset: hold rst_i=0 with full_i=1 and ready_i=1 -> all outputs 0. Assert rst_i=0 asynchronously between edges during SEND -> valid_o falls before the next edge.
2. Basic frame: data_i[k]=32'h100+k, full_i=1, ready_i=1 -> ena_rd_o is a single 1-cycle pulse 3 edges after full_i; 16 consecutive words 0x100..0x10F; last_o only with 0x10F; frm_o=1. Randomising data_i after capture leaves the output unchanged.
3. Backpressure: ready_i alternating 1/0 -> each word is held stable while ready_i=0; exactly 16 transfers over 32 SEND cycles, in order, no duplicates.
4. Re-trigger: keep full_i=1 after the frame -> no second frame (state stays DONE). Drop full_i for 3 cycles, then raise it -> second frame sent and frm_o=2.
5. Overflow: during SEND at word 5, full_i low 4 cycles then high -> ovf_o=1, and the current frame still emits all 16 words. A clr_i pulse -> ovf_o=0, frm_o=0.
6. Reset mid-frame: rst_i=0 at word 7, released with full_i still 1 -> new capture, and output restarts at shadow[0] with the current data_i values.
